gbc_apu_mixer: RTL and testbench

// Parametrised N-channel APU mixer/resampler: the sample-timing stage after the channel generators. Converts per-channel 4-bit
// DAC codes to signed levels, applies NR51-style panning and NR50-style master volume, emits stereo PCM at a fixed tick rate

---
 rtl/gbc_apu_mixer.sv | 268 ++++++++++++++++++++++++++
 tb/tb_gbc_apu_mixer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gbc_apu_mixer.sv
// N-channel APU mixer: tick-paced snapshot, serial per-channel accumulate, NR50 scale, stereo PCM out through a show-ahead FIFO.
// Optional DC blocker after scaling is enabled by defining GBC_APU_HPF_EN.
module gbc_apu_mixer #(
    parameter int unsigned CHANNELS   = 4,
    parameter int unsigned IN_WIDTH   = 4,
    parameter int unsigned OUT_WIDTH  = 24,
    parameter int unsigned SAMPLE_DIV = 875,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned HPF_SHIFT  = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         apu_on_i,
    input  logic [CHANNELS*IN_WIDTH-1:0] ch_sample_i,
    input  logic [CHANNELS-1:0]          ch_enable_i,
    input  logic [CHANNELS-1:0]          pan_right_i,
    input  logic [CHANNELS-1:0]          pan_left_i,
    input  logic [2:0]                   vol_left_i,
    input  logic [2:0]                   vol_right_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [OUT_WIDTH-1:0]         out_left_o,
    output logic [OUT_WIDTH-1:0]         out_right_o,
    output logic                         overrun_o
);
    localparam int unsigned ACC_W = $clog2((2**IN_WIDTH-1)*CHANNELS*8+1)+1;
    localparam int unsigned LVL_W = IN_WIDTH+2;
    localparam int unsigned SHIFT = OUT_WIDTH-ACC_W;
    localparam int unsigned CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int unsigned CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned OCC_W = PTR_W+1;

    typedef enum logic [2:0] {S_IDLE, S_ACCUM, S_SCALE, S_FILT, S_PUSH} state_t;
    typedef struct packed {
        logic [OUT_WIDTH-1:0] left;
        logic [OUT_WIDTH-1:0] right;
    } pair_t;

    state_t                         state_q, state_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic                           tick;
    logic [CH_W-1:0]                ch_q, ch_d;
    logic signed [ACC_W-1:0]        acc_l_q, acc_l_d, acc_r_q, acc_r_d;
    logic [CHANNELS*IN_WIDTH-1:0]   code_q, code_d;
    logic [CHANNELS-1:0]            en_q, en_d, pl_q, pl_d, pr_q, pr_d;
    logic [2:0]                     vl_q, vl_d, vr_q, vr_d;
    logic                           on_q, on_d;
    logic [IN_WIDTH-1:0]            code;
    logic signed [LVL_W-1:0]        lvl;
    logic signed [4:0]              fac_l, fac_r;
    logic signed [ACC_W+4:0]        prod_l, prod_r;
    logic                           push;
    logic signed [OUT_WIDTH-1:0]    res_l, res_r;

    always_comb begin
        tick  = (cnt_q == CNT_W'(SAMPLE_DIV-1));
        cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    // Current channel's signed level from its snapshotted DAC code
    always_comb begin
        code   = code_q[ch_q*IN_WIDTH +: IN_WIDTH];
        lvl    = en_q[ch_q] ? ($signed({1'b0, code, 1'b0}) - $signed(LVL_W'(2**IN_WIDTH-1))) : '0;
        fac_l  = $signed({2'b00, vl_q} + 5'd1);
        fac_r  = $signed({2'b00, vr_q} + 5'd1);
        prod_l = (ACC_W+5)'(acc_l_q) * (ACC_W+5)'(fac_l);
        prod_r = (ACC_W+5)'(acc_r_q) * (ACC_W+5)'(fac_r);
    end

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        acc_l_d = acc_l_q;
        acc_r_d = acc_r_q;
        code_d  = code_q;
        en_d    = en_q;
        pl_d    = pl_q;
        pr_d    = pr_q;
        vl_d    = vl_q;
        vr_d    = vr_q;
        on_d    = on_q;
        push    = 1'b0;
        case (state_q)
            S_IDLE: if (tick) begin
                code_d  = ch_sample_i;
                en_d    = ch_enable_i;
                pl_d    = pan_left_i;
                pr_d    = pan_right_i;
                vl_d    = vol_left_i;
                vr_d    = vol_right_i;
                on_d    = apu_on_i;
                acc_l_d = '0;
                acc_r_d = '0;
                ch_d    = '0;
                state_d = S_ACCUM;
            end
            S_ACCUM: begin
                if (pl_q[ch_q]) acc_l_d = acc_l_q + ACC_W'(lvl);
                if (pr_q[ch_q]) acc_r_d = acc_r_q + ACC_W'(lvl);
                if (ch_q == CH_W'(CHANNELS-1)) state_d = S_SCALE;
                else                           ch_d    = ch_q + 1'b1;
            end
            S_SCALE: begin
                acc_l_d = on_q ? ACC_W'(prod_l) : '0;
                acc_r_d = on_q ? ACC_W'(prod_r) : '0;
`ifdef GBC_APU_HPF_EN
                state_d = S_FILT;
`else
                state_d = S_PUSH;
`endif
            end
            S_FILT: state_d = S_PUSH;
            S_PUSH: begin
                push    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef GBC_APU_HPF_EN
    localparam int unsigned HW    = ACC_W+HPF_SHIFT+2;
    localparam int unsigned EXT_W = HW+SHIFT;

    logic signed [HW-1:0]        xp_l_q, xp_l_d, yp_l_q, yp_l_d, xp_r_q, xp_r_d, yp_r_q, yp_r_d;
    logic signed [HW-1:0]        y_l, y_r;
    logic signed [OUT_WIDTH-1:0] filt_l_q, filt_l_d, filt_r_q, filt_r_d;

    function automatic logic signed [HW-1:0] hpf_step(input logic signed [HW-1:0] x,
                                                      input logic signed [HW-1:0] xp,
                                                      input logic signed [HW-1:0] yp);
        return x - xp + yp - (yp >>> HPF_SHIFT);
    endfunction

    function automatic logic signed [OUT_WIDTH-1:0] sat_out(input logic signed [HW-1:0] y);
        logic signed [EXT_W-1:0]    ys;
        logic [EXT_W-OUT_WIDTH:0]   hi;
        ys = EXT_W'(y) <<< SHIFT;
        hi = ys[EXT_W-1:OUT_WIDTH-1];
        if ((&hi) || !(|hi)) return ys[OUT_WIDTH-1:0];
        return ys[EXT_W-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}} : {1'b0, {(OUT_WIDTH-1){1'b1}}};
    endfunction

    // Filter history follows the APU power state, not the snapshot
    always_comb begin
        y_l      = hpf_step(HW'(acc_l_q), xp_l_q, yp_l_q);
        y_r      = hpf_step(HW'(acc_r_q), xp_r_q, yp_r_q);
        xp_l_d   = xp_l_q;
        yp_l_d   = yp_l_q;
        xp_r_d   = xp_r_q;
        yp_r_d   = yp_r_q;
        filt_l_d = filt_l_q;
        filt_r_d = filt_r_q;
        if (state_q == S_FILT) begin
            filt_l_d = sat_out(y_l);
            filt_r_d = sat_out(y_r);
            xp_l_d   = HW'(acc_l_q);
            xp_r_d   = HW'(acc_r_q);
            yp_l_d   = y_l;
            yp_r_d   = y_r;
        end
        if (!apu_on_i) begin
            xp_l_d = '0;
            yp_l_d = '0;
            xp_r_d = '0;
            yp_r_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xp_l_q   <= '0;
            yp_l_q   <= '0;
            xp_r_q   <= '0;
            yp_r_q   <= '0;
            filt_l_q <= '0;
            filt_r_q <= '0;
        end else begin
            xp_l_q   <= xp_l_d;
            yp_l_q   <= yp_l_d;
            xp_r_q   <= xp_r_d;
            yp_r_q   <= yp_r_d;
            filt_l_q <= filt_l_d;
            filt_r_q <= filt_r_d;
        end
    end

    assign res_l = filt_l_q;
    assign res_r = filt_r_q;
`else
    assign res_l = OUT_WIDTH'(acc_l_q) <<< SHIFT;
    assign res_r = OUT_WIDTH'(acc_r_q) <<< SHIFT;
`endif

    pair_t              mem_q [FIFO_DEPTH];
    pair_t              wr_data, head_q, head_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]   occ_q, occ_d;
    logic               valid_q, valid_d, ovr_q, ovr_d;
    logic               pop, full, wr_en;

    // Show-ahead FIFO; head registered from next-state so outputs stay flop-driven
    always_comb begin
        wr_data  = '{left: res_l, right: res_r};
        pop      = valid_q & out_ready_i;
        full     = (occ_q == OCC_W'(FIFO_DEPTH));
        wr_en    = push & (~full | pop);
        ovr_d    = push & full & ~pop;
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        wr_ptr_d = wr_ptr_q + PTR_W'(wr_en);
        occ_d    = occ_q + OCC_W'(wr_en) - OCC_W'(pop);
        valid_d  = (occ_d != '0);
        head_d   = '0;
        if (valid_d) head_d = (wr_en && (wr_ptr_q == rd_ptr_d)) ? wr_data : mem_q[rd_ptr_d];
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            ch_q     <= '0;
            acc_l_q  <= '0;
            acc_r_q  <= '0;
            code_q   <= '0;
            en_q     <= '0;
            pl_q     <= '0;
            pr_q     <= '0;
            vl_q     <= '0;
            vr_q     <= '0;
            on_q     <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            valid_q  <= 1'b0;
            head_q   <= '0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ch_q     <= ch_d;
            acc_l_q  <= acc_l_d;
            acc_r_q  <= acc_r_d;
            code_q   <= code_d;
            en_q     <= en_d;
            pl_q     <= pl_d;
            pr_q     <= pr_d;
            vl_q     <= vl_d;
            vr_q     <= vr_d;
            on_q     <= on_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            valid_q  <= valid_d;
            head_q   <= head_d;
            ovr_q    <= ovr_d;
        end
    end

    assign out_valid_o = valid_q;
    assign out_left_o  = head_q.left;
    assign out_right_o = head_q.right;
    assign overrun_o   = ovr_q;
endmodule

// File: tb/tb_gbc_apu_mixer.sv
// Randomized bench for gbc_apu_mixer: tick-level arithmetic model plus a queue model of the output buffer.
module tb_gbc_apu_mixer;
    localparam int unsigned CH    = 4;
    localparam int unsigned IW    = 4;
    localparam int unsigned OW    = 24;
    localparam int unsigned DIV   = 16;
    localparam int unsigned DEPTH = 4;
    localparam int          MAXC  = 15;
    localparam int          SH    = 14;
`ifdef GBC_APU_HPF_EN
    localparam int unsigned LAT   = CH+3;
`else
    localparam int unsigned LAT   = CH+2;
`endif
    localparam int unsigned FIRST_VALID = DIV-1+LAT+1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              apu_on;
    logic [CH*IW-1:0]  ch_sample;
    logic [CH-1:0]     ch_enable, pan_right, pan_left;
    logic [2:0]        vol_left, vol_right;
    logic              out_valid, out_ready, overrun;
    logic [OW-1:0]     out_left, out_right;

    gbc_apu_mixer #(
        .CHANNELS(CH), .IN_WIDTH(IW), .OUT_WIDTH(OW), .SAMPLE_DIV(DIV), .FIFO_DEPTH(DEPTH), .HPF_SHIFT(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .apu_on_i(apu_on), .ch_sample_i(ch_sample), .ch_enable_i(ch_enable),
        .pan_right_i(pan_right), .pan_left_i(pan_left), .vol_left_i(vol_left), .vol_right_i(vol_right),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_left_o(out_left), .out_right_o(out_right),
        .overrun_o(overrun)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int            due;
        logic [OW-1:0] l;
        logic [OW-1:0] r;
    } smp_t;

    smp_t              pend_q[$];
    logic [2*OW-1:0]   fifo_q[$];
    smp_t              s_new, s_old;
    int                checks = 0;
    int                errors = 0;
    int                cyc = 0;
    int                ovr_seen = 0;
    bit                exp_ovr = 1'b0;
    int                xp[2], yp[2];
    int                lat, ov0, sl, sr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int side(input logic on, input logic [CH*IW-1:0] codes, input logic [CH-1:0] en,
                                input logic [CH-1:0] pan, input logic [2:0] vol);
        int s = 0;
        if (!on) return 0;
        for (int k = 0; k < CH; k++)
            if (en[k] && pan[k]) s += 2*int'(codes[k*IW +: IW]) - MAXC;
        return s * (int'(vol) + 1);
    endfunction

    function automatic logic [OW-1:0] sat24(input longint v);
        if (v > longint'(8388607))  return 24'h7FFFFF;
        if (v < -longint'(8388608)) return 24'h800000;
        return OW'(v);
    endfunction

    // Model: one sample per tick, due in the buffer LAT cycles later; pop precedes push each edge
    always @(posedge clk) begin
        if (!rst_n) begin
            cyc = 0;
            pend_q.delete();
            fifo_q.delete();
            exp_ovr = 1'b0;
            xp[0] = 0; xp[1] = 0; yp[0] = 0; yp[1] = 0;
        end else begin
            exp_ovr = 1'b0;
            if (fifo_q.size() != 0 && out_ready) void'(fifo_q.pop_front());
            if (pend_q.size() != 0 && pend_q[0].due == cyc) begin
                s_old = pend_q.pop_front();
                if (fifo_q.size() < DEPTH) fifo_q.push_back({s_old.l, s_old.r});
                else                       exp_ovr = 1'b1;
            end
`ifdef GBC_APU_HPF_EN
            if (!apu_on) begin
                xp[0] = 0; xp[1] = 0; yp[0] = 0; yp[1] = 0;
            end
`endif
            if (cyc % DIV == DIV-1) begin
                sl = side(apu_on, ch_sample, ch_enable, pan_left, vol_left);
                sr = side(apu_on, ch_sample, ch_enable, pan_right, vol_right);
                s_new.due = cyc + LAT;
`ifdef GBC_APU_HPF_EN
                begin
                    int yl, yr;
                    yl = sl - xp[0] + yp[0] - (yp[0] >>> 8);
                    yr = sr - xp[1] + yp[1] - (yp[1] >>> 8);
                    xp[0] = sl; yp[0] = yl; xp[1] = sr; yp[1] = yr;
                    s_new.l = sat24(longint'(yl) * 16384);
                    s_new.r = sat24(longint'(yr) * 16384);
                end
`else
                s_new.l = OW'(sl * (1 << SH));
                s_new.r = OW'(sr * (1 << SH));
`endif
                pend_q.push_back(s_new);
            end
            cyc++;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_valid", 32'(out_valid), 32'd0);
            check("rst_left", 32'(out_left), 32'd0);
            check("rst_overrun", 32'(overrun), 32'd0);
        end else begin
            check("valid", 32'(out_valid), 32'(fifo_q.size() != 0));
            if (fifo_q.size() != 0) begin
                check("left", 32'(out_left), 32'(fifo_q[0][2*OW-1:OW]));
                check("right", 32'(out_right), 32'(fifo_q[0][OW-1:0]));
            end
            check("overrun", 32'(overrun), 32'(exp_ovr));
            if (overrun) ovr_seen++;
        end
    end

    // Park at the point in the sample period where the buffer is idle and nothing is in flight
    task automatic align();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((cyc % DIV) != 7 && n < 4*DIV);
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 4*DIV) begin
            @(negedge clk);
            n++;
        end
        check("valid_timeout", 32'(out_valid), 32'd1);
    endtask

    task automatic full_scale();
        ch_sample = '1;
        ch_enable = '1;
        pan_left  = '1;
        pan_right = '1;
        vol_left  = 3'd7;
        vol_right = 3'd7;
        apu_on    = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        out_ready = 1'b1;
        apu_on = 1'b1;
        ch_sample = '0; ch_enable = '0; pan_left = '0; pan_right = '0; vol_left = '0; vol_right = '0;
        repeat (3) @(negedge clk);
        check("reset_valid", 32'(out_valid), 32'd0);
        check("reset_left", 32'(out_left), 32'd0);
        check("reset_right", 32'(out_right), 32'd0);
        check("reset_overrun", 32'(overrun), 32'd0);

        full_scale();
        rst_n = 1'b1;
        wait_valid(lat);
        check("first_latency", 32'(lat), 32'(FIRST_VALID));
        check("fs_left", 32'(out_left), 32'h780000);
        check("fs_right", 32'(out_right), 32'h780000);
        repeat (3*DIV) @(negedge clk);

`ifndef GBC_APU_HPF_EN
        align();
        ch_sample = '0;
        wait_valid(lat);
        check("zero_left", 32'(out_left), 32'h880000);
        check("zero_right", 32'(out_right), 32'h880000);

        align();
        ch_sample = 16'h0008;
        pan_left  = 4'b0001;
        pan_right = 4'b0000;
        vol_left  = 3'd0;
        wait_valid(lat);
        check("ch0_left", 32'(out_left), 32'h004000);
        check("ch0_right", 32'(out_right), 32'h000000);
`endif

        // Back-pressure: six ticks with the consumer stalled
        align();
        ov0 = ovr_seen;
        out_ready = 1'b0;
        repeat (6*DIV) @(negedge clk);
        check("overrun_pulses", 32'(ovr_seen - ov0), 32'd2);
        check("held_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        repeat (2*DIV) @(negedge clk);

        align();
        apu_on = 1'b0;
        ch_sample = 16'(($urandom));
        repeat (4*DIV) @(negedge clk);
        align();
        apu_on = 1'b1;

        for (int i = 0; i < 40*DIV; i++) begin
            @(negedge clk);
            out_ready = ($urandom % 4) != 0;
            if ((i % 5) == 0) begin
                ch_sample = 16'($urandom);
                ch_enable = 4'($urandom);
                pan_left  = 4'($urandom);
                pan_right = 4'($urandom);
                vol_left  = 3'($urandom);
                vol_right = 3'($urandom);
            end
        end

        // Asynchronous reset in the middle of accumulation with samples buffered
        out_ready = 1'b0;
        repeat (2*DIV) @(negedge clk);
        begin
            int n = 0;
            while ((cyc % DIV) != 1 && n < 4*DIV) begin
                @(negedge clk);
                n++;
            end
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_valid", 32'(out_valid), 32'd0);
        check("async_left", 32'(out_left), 32'd0);
        check("async_right", 32'(out_right), 32'd0);
        repeat (3) @(negedge clk);
        full_scale();
        out_ready = 1'b1;
        rst_n = 1'b1;
        wait_valid(lat);
        check("rerun_latency", 32'(lat), 32'(FIRST_VALID));
        repeat (DIV) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
